// File: rtl/program_loader.sv
// Framed byte-stream boot loader: assembles little-endian words into program memory
// and releases the core from reset once the XOR checksum of the frame matches.
module program_loader #(
    parameter int MEMORY_DEPTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_reset,
    output logic        load_done,
    output logic        load_error
);

    localparam int         IW        = $clog2(MEMORY_DEPTH) + 1;
    localparam logic [7:0] MAX_COUNT = 8'(MEMORY_DEPTH);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        WRITE = 3'd2,
        CHECK = 3'd3,
        RUN   = 3'd4,
        ERROR = 3'd5
    } state_t;

    state_t          state_r;
    logic [7:0]      count_r;
    logic [7:0]      xor_r;
    logic [IW-1:0]   idx_r;
    logic [1:0]      bcnt_r;
    logic [23:0]     buf_r;
    logic            accept_s;
    logic [7:0]      idx_next_s;

    // Ready is decoded from state so that a byte can be taken in the first cycle after reset
    assign rx_ready   = ~reset & ((state_r == IDLE) | (state_r == RECV) | (state_r == CHECK));
    assign accept_s   = rx_valid & rx_ready;
    assign idx_next_s = 8'(idx_r) + 8'd1;

    // Frame sequencing, word assembly, checksum tracking and registered memory/core controls
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            count_r    <= 8'd0;
            xor_r      <= 8'd0;
            idx_r      <= '0;
            bcnt_r     <= 2'd0;
            buf_r      <= 24'd0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
            cpu_reset  <= 1'b1;
            load_done  <= 1'b0;
            load_error <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        count_r <= rx_data;
                        xor_r   <= rx_data;
                        idx_r   <= '0;
                        bcnt_r  <= 2'd0;
                        if (rx_data > MAX_COUNT) begin
                            state_r    <= ERROR;
                            load_error <= 1'b1;
                        end else if (rx_data == 8'd0) begin
                            state_r <= CHECK;
                        end else begin
                            state_r <= RECV;
                        end
                    end
                end
                RECV: begin
                    if (accept_s) begin
                        xor_r  <= xor_r ^ rx_data;
                        bcnt_r <= bcnt_r + 2'd1;
                        case (bcnt_r)
                            2'd0: buf_r[7:0]   <= rx_data;
                            2'd1: buf_r[15:8]  <= rx_data;
                            2'd2: buf_r[23:16] <= rx_data;
                            default: begin
                                // Top byte goes straight to the write data register
                                mem_we    <= 1'b1;
                                mem_addr  <= {{(30-IW){1'b0}}, idx_r, 2'b00};
                                mem_wdata <= {rx_data, buf_r};
                                state_r   <= WRITE;
                            end
                        endcase
                    end
                end
                WRITE: begin
                    idx_r <= idx_r + {{(IW-1){1'b0}}, 1'b1};
                    if (idx_next_s == count_r) begin
                        state_r <= CHECK;
                    end else begin
                        state_r <= RECV;
                    end
                end
                CHECK: begin
                    if (accept_s) begin
                        if (rx_data == xor_r) begin
                            state_r   <= RUN;
                            cpu_reset <= 1'b0;
                            load_done <= 1'b1;
                        end else begin
                            state_r    <= ERROR;
                            load_error <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    state_r <= RUN;
                end
                ERROR: begin
                    state_r <= ERROR;
                end
                default: begin
                    state_r    <= ERROR;
                    cpu_reset  <= 1'b1;
                    load_done  <= 1'b0;
                    load_error <= 1'b1;
                end
            endcase
        end
    end

endmodule
